// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, complex word type, FSM states, twiddle ROM and bit reversal for the 32-point FFT.
package fft_pkg;
  localparam int N_POINTS = 32;
  localparam int LOG2N = 5;
  localparam int DW = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;
  // W^k = {round(1023*cos(2*pi*k/32)), -round(1023*sin(2*pi*k/32))}
  localparam logic [2*DW-1:0] TWIDDLE [N_POINTS/2] = '{
    32'h03FF_0000, 32'h03EB_FF38, 32'h03B1_FE79, 32'h0353_FDC8,
    32'h02D3_FD2D, 32'h0238_FCAD, 32'h0187_FC4F, 32'h00C8_FC15,
    32'h0000_FC01, 32'hFF38_FC15, 32'hFE79_FC4F, 32'hFDC8_FCAD,
    32'hFD2D_FD2D, 32'hFCAD_FDC8, 32'hFC4F_FE79, 32'hFC15_FF38
  };
  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction
endpackage

// File: rtl/fft32_engine_butterflyunit.sv
// butterflyunit: combinational radix-2 DIT butterfly, A_f = A + W*B, B_f = A - W*B (W in Q10, rounded).
// FFT_STAGE_SCALE_EN: both outputs arithmetic-shifted right by one before leaving the unit.
module butterflyunit
  import fft_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  input  cplx_t w_i,
  output cplx_t af_o,
  output cplx_t bf_o
);
`ifdef FFT_STAGE_SCALE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  localparam int PW = 2*DW+2;
  logic signed [PW-1:0] p_re, p_im;
  always_comb begin
    p_re = (PW'(w_i.re) * PW'(b_i.re) - PW'(w_i.im) * PW'(b_i.im) + PW'(512)) >>> 10;
    p_im = (PW'(w_i.re) * PW'(b_i.im) + PW'(w_i.im) * PW'(b_i.re) + PW'(512)) >>> 10;
    // shift the full-precision sum so scaling never sees a wrapped value
    af_o.re = DW'((PW'(a_i.re) + p_re) >>> SH);
    af_o.im = DW'((PW'(a_i.im) + p_im) >>> SH);
    bf_o.re = DW'((PW'(a_i.re) - p_re) >>> SH);
    bf_o.im = DW'((PW'(a_i.im) - p_im) >>> SH);
  end
endmodule

// File: rtl/fft32_engine.sv
// fft32_engine: iterative radix-2 DIT 32-point FFT; loads 32 samples bit-reversed, runs 80 butterflies
// (one per clock), then streams bins in natural order. Optional per-stage scaling: FFT_STAGE_SCALE_EN.
module fft32_engine
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*DW-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*DW-1:0]      out_data,
  output logic [LOG2N-1:0]     out_index,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);
  state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2*DW-1:0] mem_q [N_POINTS];
  logic [2:0] s;
  logic [3:0] b, k;
  logic [4:0] half, top_a, bot_a;
  logic adv, wrap;
  cplx_t af, bf;
  always_comb begin
    // one counter serves as load index, {stage,butterfly} during compute, and bin index
    s = cnt_q[6:4];
    b = cnt_q[3:0];
    half = 5'd1 << s;
    top_a = (({1'b0, b} >> s) << (s + 3'd1)) | ({1'b0, b} & (half - 5'd1));
    bot_a = top_a | half;
    k = (b & 4'(half - 5'd1)) << (3'd4 - s);
    in_ready = state_q == LOAD;
    busy = state_q == COMPUTE;
    out_valid = state_q == UNLOAD;
    out_index = out_valid ? cnt_q[4:0] : '0;
    out_data = out_valid ? mem_q[cnt_q[4:0]] : '0;
    out_last = out_valid && cnt_q[4:0] == 5'd31;
    adv = (in_ready && in_valid) || busy || (out_valid && out_ready);
    wrap = cnt_q == (busy ? 7'd79 : 7'd31);
    cnt_d = adv ? (wrap ? 7'd0 : cnt_q + 7'd1) : cnt_q;
    state_d = !(adv && wrap) ? state_q :
              state_q == LOAD ? COMPUTE :
              state_q == COMPUTE ? UNLOAD : LOAD;
  end
  butterflyunit u_bfly (
    .a_i (mem_q[top_a]),
    .b_i (mem_q[bot_a]),
    .w_i (TWIDDLE[k]),
    .af_o(af),
    .bf_o(bf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) mem_q[bitrev5(cnt_q[4:0])] <= in_data;
    if (busy) begin
      mem_q[top_a] <= af;
      mem_q[bot_a] <= bf;
    end
  end
endmodule

// File: tb/tb_fft32_engine.sv
// tb_fft32_engine: directed frames checked against a behavioural FFT model plus literal impulse/DC bins.
module tb_fft32_engine;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_last, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [4:0] out_index;
  int compared = 0, mismatched = 0;
  int exp_idx = 0;
  int tw_re[16], tw_im[16];
  logic [31:0] x[32], expv[32], lit[32];
  bit lit_en;

  fft32_engine dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic int rev5(input int v);
    int r = 0;
    for (int i = 0; i < 5; i++) r |= ((v >> i) & 1) << (4 - i);
    return r;
  endfunction

  // textbook in-place DIT FFT on plain ints, wrapping every value to 16 bits
  function automatic void run_model();
    logic [31:0] a[32];
    for (int i = 0; i < 32; i++) a[rev5(i)] = x[i];
    for (int st = 0; st < 5; st++) begin
      int h = 1 << st;
      for (int g = 0; g < 32; g += 2 * h)
        for (int m = 0; m < h; m++) begin
          int ar, ai, br, bi, wr, wi, pr, pi, kk;
          kk = m * (16 >> st);
          wr = tw_re[kk]; wi = tw_im[kk];
          ar = int'($signed(a[g+m][31:16]));   ai = int'($signed(a[g+m][15:0]));
          br = int'($signed(a[g+m+h][31:16])); bi = int'($signed(a[g+m+h][15:0]));
          pr = (wr * br - wi * bi + 512) >>> 10;
          pi = (wr * bi + wi * br + 512) >>> 10;
          a[g+m]   = {16'(ar + pr), 16'(ai + pi)};
          a[g+m+h] = {16'(ar - pr), 16'(ai - pi)};
        end
    end
    for (int i = 0; i < 32; i++) expv[i] = a[i];
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !out_valid) exp_idx = 0;
    else begin
      if (exp_idx > 31) chk("out_extra", {27'd0, out_index}, 32'hFFFF_FFFF);
      else begin
        chk("out_index", {27'd0, out_index}, exp_idx);
        chk("out_data", out_data, expv[exp_idx]);
        chk("out_last", {31'd0, out_last}, {31'd0, exp_idx == 31});
        if (lit_en) chk("out_literal", out_data, lit[exp_idx]);
      end
      if (out_ready) exp_idx++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_index"}, {27'd0, out_index}, 0);
  endtask

  task automatic load_frame(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) begin
        in_valid = 0; in_data = $urandom;
        @(posedge clk); #1;
        chk("in_ready_gap", {31'd0, in_ready}, 1);
      end
      in_valid = 1; in_data = x[i];
      chk("in_ready_load", {31'd0, in_ready}, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic frame(input bit gaps, input bit bp);
    int n = 0, g = 0;
    run_model();
    load_frame(gaps);
    while (busy && n < 200) begin
      chk("in_ready_compute", {31'd0, in_ready}, 0);
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    chk("compute_cycles", n, 80);
    chk("out_valid_rise", {31'd0, out_valid}, 1);
    chk("in_ready_unload", {31'd0, in_ready}, 0);
    while (exp_idx < 32 && g < 2000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      g++;
    end
    out_ready = 0;
    chk("bins_seen", exp_idx, 32);
    chk("post_out_valid", {31'd0, out_valid}, 0);
    chk("post_in_ready", {31'd0, in_ready}, 1);
    chk("post_out_index", {27'd0, out_index}, 0);
  endtask

  task automatic set_impulse();
    for (int i = 0; i < 32; i++) begin
      x[i] = (i == 0) ? 32'h0100_0000 : 32'h0;
      lit[i] = 32'h0100_0000;
    end
    lit_en = 1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      tw_re[k] = int'(1023.0 * $cos(2.0 * 3.14159265358979 * k / 32.0));
      tw_im[k] = -int'(1023.0 * $sin(2.0 * 3.14159265358979 * k / 32.0));
    end
    rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; lit_en = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;
    set_impulse();
    frame(0, 0);
    for (int i = 0; i < 32; i++) begin
      x[i] = 32'h0010_0000;
      lit[i] = (i == 0) ? 32'h0200_0000 : 32'h0;
    end
    frame(1, 1);
    lit_en = 0;
    for (int i = 0; i < 32; i++)
      x[i] = {16'($urandom_range(0, 2047) - 1024), 16'($urandom_range(0, 2047) - 1024)};
    frame(0, 1);
    for (int i = 0; i < 32; i++) x[i] = {16'($urandom_range(0, 2047) - 1024), 16'(0)};
    frame(1, 0);
    set_impulse();
    for (int i = 0; i < 32; i++) x[i] = 32'h0123_0456 + i;
    load_frame(0);
    repeat (40) @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("held_reset");
    rst_n = 1;
    set_impulse();
    frame(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
